// File: rtl/sine_filter_if.sv
// Sample bus for the sine/pulse-shaping FIR.
// Ports (signals):
//   x_in : signed 1s17 input sample, driven by the master every clock
//   y    : signed 1s17 filtered output, driven by the filter
// Modports:
//   master : drives x_in, observes y (sample source / testbench)
//   slave  : observes x_in, drives y (the filter)
interface sine_filter_if #(
    parameter int DATA_W = 18
);
    logic signed [DATA_W-1:0] x_in;
    logic signed [DATA_W-1:0] y;

    modport master (output x_in, input y);
    modport slave  (input x_in, output y);
endinterface

// File: rtl/sine_filter.sv
// Fixed-coefficient 17-tap symmetric low-pass FIR, one sample per clock.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-low reset, clears every pipeline register
//   bus   : sine_filter_if slave (x_in in, y out), both signed 1s17
// Pipeline: d[0..16] delay line (d[0] is the input register) -> symmetric
// pre-add -> 9 multiplies -> accumulate -> registered y.  A sample taken at
// edge E shows its h0 term on y after edge E+4 and its h_k term after E+4+k.
module sine_filter #(
    parameter int DATA_W = 18,
    parameter int NTAPS  = 17
) (
    input  logic          clk,
    input  logic          reset,
    sine_filter_if.slave  bus
);

    localparam int NHALF  = NTAPS / 2;       // index of the centre tap (8)
    localparam int NUNIQ  = NHALF + 1;       // distinct coefficients (9)
    localparam int PRE_W  = DATA_W + 1;      // pre-add width (19)
    localparam int PROD_W = PRE_W + DATA_W;  // product width (37)
    localparam int ACC_W  = PROD_W + 1;      // accumulator width (38)

    // h[k] = h[16-k]; only the first half plus the centre tap are stored.
    localparam logic signed [DATA_W-1:0] H [NUNIQ] = '{
        -18'sd327, -18'sd655, 18'sd0,     18'sd1966,
         18'sd5243, 18'sd9830, 18'sd14418, 18'sd17694,
         18'sd18350
    };

    logic signed [DATA_W-1:0] d    [NTAPS];
    logic signed [PRE_W-1:0]  pre  [NUNIQ];
    logic signed [PROD_W-1:0] prod [NUNIQ];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [DATA_W-1:0] y_r;

    // Delay line; d[0] doubles as the input register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NTAPS; i++) d[i] <= '0;
        end else begin
            d[0] <= bus.x_in;
            for (int i = 1; i < NTAPS; i++) d[i] <= d[i-1];
        end
    end

    // Fold symmetric taps so only 9 multipliers are needed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUNIQ; k++) pre[k] <= '0;
        end else begin
            for (int k = 0; k < NHALF; k++)
                pre[k] <= {d[k][DATA_W-1], d[k]}
                        + {d[NTAPS-1-k][DATA_W-1], d[NTAPS-1-k]};
            pre[NHALF] <= {d[NHALF][DATA_W-1], d[NHALF]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUNIQ; k++) prod[k] <= '0;
        end else begin
            for (int k = 0; k < NUNIQ; k++)
                prod[k] <= PROD_W'(pre[k]) * PROD_W'(H[k]);
        end
    end

    always_comb begin
        acc_sum = '0;
        for (int k = 0; k < NUNIQ; k++)
            acc_sum = acc_sum + ACC_W'(prod[k]);
    end

    // Sum of |h| is below 2^17, so acc[34:17] never wraps; dropping the low
    // bits floors toward minus infinity.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc <= '0;
            y_r <= '0;
        end else begin
            acc <= acc_sum;
            y_r <= acc[DATA_W+16:17];
        end
    end

    assign bus.y = y_r;

    logic unused_acc_bits;
    assign unused_acc_bits = ^{acc[ACC_W-1:DATA_W+17], acc[16:0]};

endmodule

// File: tb/tb_sine_filter.sv
// Directed self-checking bench for sine_filter: reset, impulse, DC step,
// negative full scale, mid-stream reset and ramp.
module tb_sine_filter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    sine_filter_if #(.DATA_W(18)) bus ();

    sine_filter #(.DATA_W(18), .NTAPS(17)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Impulse response for a 65536 input: floor(h_k / 2).
    int imp_exp [17] = '{-164, -328, 0, 983, 2621, 4915, 7209, 8847, 9175,
                         8847, 7209, 4915, 2621, 983, 0, -328, -164};
    int coef [17]    = '{-327, -655, 0, 1966, 5243, 9830, 14418, 17694, 18350,
                         17694, 14418, 9830, 5243, 1966, 0, -655, -327};

    task automatic check_val(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Advance one rising edge; outputs are then read 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int yv();
        return int'(bus.y);
    endfunction

    initial begin
        int cum;
        int m;
        longint prodl;
        checks   = 0;
        failures = 0;

        // Reset held with non-zero input.
        reset    = 1'b0;
        bus.x_in = 18'sd100000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("reset_hold", yv(), 0);
        end
        reset    = 1'b1;
        bus.x_in = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("reset_release", yv(), 0);
        end

        // Impulse.
        bus.x_in = 18'sd65536;
        tick();
        bus.x_in = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("imp_latency", yv(), 0);
        end
        for (int k = 0; k < 17; k++) begin
            tick();
            check_val($sformatf("imp_tap%0d", k), yv(), imp_exp[k]);
        end
        tick();
        check_val("imp_tail", yv(), 0);

        // DC step: settles after edge E+20.
        bus.x_in = 18'sd65536;
        for (int i = 0; i < 21; i++) tick();
        for (int i = 0; i < 4; i++) begin
            check_val("dc_step", yv(), 57344);
            tick();
        end

        // Mid-stream reset: one reset edge, then refill with no residue.
        reset = 1'b0;
        tick();
        check_val("mid_reset", yv(), 0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("mid_refill_zero", yv(), 0);
        end
        cum = 0;
        for (int k = 0; k < 17; k++) begin
            tick();
            cum = cum + coef[k];
            check_val($sformatf("mid_refill%0d", k), yv(), cum >>> 1);
        end
        tick();
        check_val("mid_settled", yv(), 57344);

        // Negative full scale.
        reset = 1'b0;
        tick();
        reset    = 1'b1;
        bus.x_in = -18'sd131072;
        for (int i = 0; i < 21; i++) tick();
        for (int i = 0; i < 3; i++) begin
            check_val("neg_full", yv(), -114688);
            tick();
        end

        // Ramp: x = n at the n-th edge; y reflects m = n-4.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int n = 0; n < 48; n++) begin
            bus.x_in = 18'(n);
            tick();
            m = n - 4;
            if (m >= 16) begin
                prodl = 64'sd114688 * longint'(m - 8);
                check_val($sformatf("ramp_m%0d", m), yv(), int'(prodl >>> 17));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
